// File: rtl/fifo_morado_if.sv
// Push/pop handshake, thresholds and status flags
// between the arbiter/consumer side and one output-lane FIFO.
interface fifo_morado_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [ADDR_WIDTH:0]   umbral_alto;
  logic [ADDR_WIDTH:0]   umbral_bajo;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  error_full;
  logic                  error_empty;

  modport master (
    output push, data_in, pop,
    output umbral_alto, umbral_bajo,
    input  data_out, valid_out,
    input  empty, full,
    input  almost_full, almost_empty,
    input  error_full, error_empty
  );

  modport slave (
    input  push, data_in, pop,
    input  umbral_alto, umbral_bajo,
    output data_out, valid_out,
    output empty, full,
    output almost_full, almost_empty,
    output error_full, error_empty
  );
endinterface

// File: rtl/fifo_morado.sv
// Output-lane FIFO: 8-deep register array, registered pop port,
// threshold flags decoded from occupancy only.
module fifo_morado #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic         clk,
  input  logic         reset_L,
  fifo_morado_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CAP =
    (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  is_empty;
  logic                  is_full;
  logic                  push_ok;
  logic                  pop_ok;

  assign is_empty = (count == '0);
  assign is_full  = (count == CAP);

  // A pop on a full FIFO frees the slot the same-edge push uses.
  assign pop_ok  = bus.pop && !is_empty;
  assign push_ok = bus.push && (!is_full || bus.pop);

  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_full  = (bus.umbral_alto != '0) &&
                            (count >= bus.umbral_alto);
  assign bus.almost_empty = (count <= bus.umbral_bajo);

  always_ff @(posedge clk) begin
    if (push_ok && reset_L)
      mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      bus.data_out    <= '0;
      bus.valid_out   <= 1'b0;
      bus.error_full  <= 1'b0;
      bus.error_empty <= 1'b0;
    end else begin
      bus.error_full  <= bus.push && is_full && !bus.pop;
      bus.error_empty <= bus.pop && is_empty;
      bus.valid_out   <= pop_ok;
      if (push_ok)
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop_ok) begin
        bus.data_out <= mem[rd_ptr];
        rd_ptr       <= rd_ptr + ADDR_WIDTH'(1);
      end
      unique case (1'b1)
        (push_ok && !pop_ok):
          count <= count + (ADDR_WIDTH+1)'(1);
        (pop_ok && !push_ok):
          count <= count - (ADDR_WIDTH+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_morado.sv
// Bench for fifo_morado: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_fifo_morado;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  fifo_morado_if #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) bus ();

  fifo_morado #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
    .clk(clk), .reset_L(reset_L), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [5:0] q[$];
  logic [5:0] m_data;
  bit m_valid, m_efull, m_eempty;

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: occupancy is the queue length; pop is served before push
  // so a full FIFO accepts a write when a read happens on the same edge.
  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      q.delete();
      m_data = '0; m_valid = 0; m_efull = 0; m_eempty = 0;
    end else begin
      automatic int n = q.size();
      automatic bit p = bus.push;
      automatic bit r = bus.pop;
      m_efull  = p && n == 8 && !r;
      m_eempty = r && n == 0;
      if (r && n > 0) begin
        m_data  = q.pop_front();
        m_valid = 1;
      end else m_valid = 0;
      if (p && (n < 8 || r)) q.push_back(bus.data_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      automatic int n = q.size();
      automatic int hi = int'(bus.umbral_alto);
      automatic int lo = int'(bus.umbral_bajo);
      chk("data_out", 8'(bus.data_out), 8'(m_data));
      chk("valid_out", 8'(bus.valid_out), 8'(m_valid));
      chk("empty", 8'(bus.empty), 8'(n == 0));
      chk("full", 8'(bus.full), 8'(n == 8));
      chk("almost_full", 8'(bus.almost_full),
          8'(hi != 0 && n >= hi));
      chk("almost_empty", 8'(bus.almost_empty), 8'(n <= lo));
      chk("error_full", 8'(bus.error_full), 8'(m_efull));
      chk("error_empty", 8'(bus.error_empty), 8'(m_eempty));
    end
  end

  task automatic cyc(input bit p, input logic [5:0] d,
                     input bit r);
    bus.push = p; bus.data_in = d; bus.pop = r;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.push = 0; bus.pop = 0; bus.data_in = '0;
    bus.umbral_alto = 4'd0; bus.umbral_bajo = 4'd2;
    repeat (2) @(posedge clk);
    #2 reset_L = 1'b1;
    chk_en = 1;
    @(posedge clk); #1;
    chk("rst empty", 8'(bus.empty), 8'd1);
    chk("rst full", 8'(bus.full), 8'd0);
    chk("rst aempty", 8'(bus.almost_empty), 8'd1);
    chk("rst valid", 8'(bus.valid_out), 8'd0);
    chk("rst data", 8'(bus.data_out), 8'd0);

    for (int i = 1; i <= 8; i++) cyc(1, 6'(i), 0);
    chk("fill full", 8'(bus.full), 8'd1);
    cyc(1, 6'h3F, 0);
    chk("ovf err", 8'(bus.error_full), 8'd1);
    chk("ovf full", 8'(bus.full), 8'd1);
    cyc(0, 0, 0);
    chk("ovf pulse", 8'(bus.error_full), 8'd0);

    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1);
      chk("drain data", 8'(bus.data_out), 8'(i));
      chk("drain valid", 8'(bus.valid_out), 8'd1);
    end
    chk("drain empty", 8'(bus.empty), 8'd1);
    cyc(0, 0, 1);
    chk("udf err", 8'(bus.error_empty), 8'd1);
    chk("udf valid", 8'(bus.valid_out), 8'd0);
    chk("udf hold", 8'(bus.data_out), 8'd8);
    cyc(0, 0, 0);
    chk("udf pulse", 8'(bus.error_empty), 8'd0);

    bus.umbral_alto = 4'd6; bus.umbral_bajo = 4'd2;
    for (int k = 1; k <= 6; k++) begin
      cyc(1, 6'(8'h20 + k), 0);
      chk("thr ae", 8'(bus.almost_empty), 8'(k <= 2));
      chk("thr af", 8'(bus.almost_full), 8'(k >= 6));
    end
    for (int k = 5; k >= 2; k--) begin
      cyc(0, 0, 1);
      chk("thr af dn", 8'(bus.almost_full), 8'd0);
      chk("thr ae dn", 8'(bus.almost_empty), 8'(k <= 2));
    end
    cyc(0, 0, 1); cyc(0, 0, 1);

    for (int i = 0; i < 8; i++) cyc(1, 6'(i), 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 6'(i + 8), 1);
      chk("wrap data", 8'(bus.data_out), 8'(i));
      chk("wrap full", 8'(bus.full), 8'd1);
      chk("wrap errf", 8'(bus.error_full), 8'd0);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1);
      chk("wrap tail", 8'(bus.data_out), 8'(i + 16));
    end

    cyc(1, 6'h15, 1);
    chk("pp err", 8'(bus.error_empty), 8'd1);
    chk("pp empty", 8'(bus.empty), 8'd0);
    chk("pp valid", 8'(bus.valid_out), 8'd0);
    cyc(0, 0, 1);
    chk("pp data", 8'(bus.data_out), 8'h15);
    chk("pp valid2", 8'(bus.valid_out), 8'd1);

    for (int i = 0; i < 5; i++) cyc(1, 6'(8'h30 + i), 0);
    cyc(0, 0, 1);
    #3 reset_L = 1'b0;
    #1;
    chk("arst empty", 8'(bus.empty), 8'd1);
    chk("arst full", 8'(bus.full), 8'd0);
    chk("arst valid", 8'(bus.valid_out), 8'd0);
    chk("arst data", 8'(bus.data_out), 8'd0);
    chk("arst ae", 8'(bus.almost_empty), 8'd1);
    chk("arst af", 8'(bus.almost_full), 8'd0);
    @(posedge clk); #3 reset_L = 1'b1;
    @(posedge clk); #1;
    cyc(1, 6'h2A, 0);
    cyc(0, 0, 1);
    chk("post rst", 8'(bus.data_out), 8'h2A);

    for (int i = 0; i < 3000; i++) begin
      automatic int bias = (i / 200) % 3;
      automatic int pp = bias == 0 ? 75 : bias == 1 ? 25 : 50;
      if ($urandom_range(0, 19) == 0) begin
        bus.umbral_alto = 4'($urandom_range(0, 8));
        bus.umbral_bajo = 4'($urandom_range(0, 10));
      end
      if (i % 700 == 350) begin
        #2 reset_L = 1'b0;
        @(posedge clk); #3 reset_L = 1'b1;
        @(posedge clk); #1;
      end
      cyc($urandom_range(0, 99) < pp, 6'($urandom),
          $urandom_range(0, 99) >= pp);
    end

    cyc(0, 0, 0);
    @(negedge clk); #1;
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
